// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 line receiver; captures shifted pixels, latches a line buffer and reads it back by column.
module hub75_rx #(
  parameter int NUM_PANELS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       lat,
  input  logic       oe_n,
  input  logic [3:0] addr,
  input  logic [2:0] rgb1,
  input  logic [2:0] rgb2,
  input  logic [7:0] rd_col,
  output logic [5:0] rd_data,
  output logic       line_vld,
  output logic [3:0] line_row,
  output logic       line_err,
  output logic [7:0] shift_cnt,
  output logic       lit
);
  localparam int WIDTH = 32 * NUM_PANELS;
  localparam int AW = $clog2(WIDTH);
  localparam logic [7:0] W8 = 8'(WIDTH);
  logic       s_sclk, s_lat, s_oe_n, p_sclk, p_lat;
  logic [3:0] s_addr;
  logic [2:0] s_rgb1, s_rgb2;
  logic       up, arm_sclk, arm_lat, seen;
  logic       sh, la, full;
  logic [5:0] pix;
  logic [7:0] cnt_nxt;
  logic [5:0] store [WIDTH];
  logic [5:0] store_nxt [WIDTH];
  logic [5:0] line_buf [WIDTH];
  // Edges only count once the signal has been seen low after reset.
  assign sh = s_sclk & ~p_sclk & arm_sclk;
  assign la = s_lat & ~p_lat & arm_lat;
  assign pix = {s_rgb1, s_rgb2};
  assign full = shift_cnt >= W8;
  assign cnt_nxt = sh && shift_cnt != W8 + 8'd1 ? shift_cnt + 8'd1 : shift_cnt;
  // Below WIDTH shifts, write by index; beyond it, slide so the newest pixel sits in the last column.
  always_comb begin
    for (int k = 0; k < WIDTH - 1; k++)
      store_nxt[k] = !sh ? store[k] : full ? store[k + 1] : shift_cnt == 8'(k) ? pix : store[k];
    store_nxt[WIDTH-1] = sh && (full || shift_cnt == W8 - 8'd1) ? pix : store[WIDTH-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sclk    <= 1'b0;
      s_lat     <= 1'b0;
      s_oe_n    <= 1'b0;
      s_addr    <= 4'd0;
      s_rgb1    <= 3'd0;
      s_rgb2    <= 3'd0;
      p_sclk    <= 1'b0;
      p_lat     <= 1'b0;
      up        <= 1'b0;
      arm_sclk  <= 1'b0;
      arm_lat   <= 1'b0;
      seen      <= 1'b0;
      line_vld  <= 1'b0;
      line_row  <= 4'd0;
      line_err  <= 1'b0;
      shift_cnt <= 8'd0;
      lit       <= 1'b0;
      rd_data   <= 6'd0;
      for (int k = 0; k < WIDTH; k++) begin
        store[k]    <= 6'd0;
        line_buf[k] <= 6'd0;
      end
    end else begin
      s_sclk    <= sclk;
      s_lat     <= lat;
      s_oe_n    <= oe_n;
      s_addr    <= addr;
      s_rgb1    <= rgb1;
      s_rgb2    <= rgb2;
      p_sclk    <= s_sclk;
      p_lat     <= s_lat;
      up        <= 1'b1;
      arm_sclk  <= arm_sclk | (up & ~s_sclk);
      arm_lat   <= arm_lat | (up & ~s_lat);
      seen      <= seen | la;
      store     <= store_nxt;
      line_vld  <= la;
      shift_cnt <= la ? 8'd0 : cnt_nxt;
      lit       <= seen & ~s_oe_n;
      rd_data   <= rd_col < W8 ? line_buf[rd_col[AW-1:0]] : 6'd0;
      if (la) begin
        line_buf <= store_nxt;
        line_row <= s_addr;
        line_err <= cnt_nxt != W8;
      end
    end
  end
endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: checks one- and two-panel receivers side by side against a pixel-queue model.
module tb_hub75_rx;
  logic clk = 0, rst_n = 0, sclk = 0, lat = 0, oe_n = 1;
  logic [3:0] addr = 0;
  logic [2:0] rgb1 = 0, rgb2 = 0;
  logic [7:0] rd_col = 0;
  logic [5:0] d1_rd, d2_rd;
  logic d1_vld, d2_vld, d1_err, d2_err, d1_lit, d2_lit;
  logic [3:0] d1_row, d2_row;
  logic [7:0] d1_cnt, d2_cnt;
  int checks = 0, errors = 0, v1 = 0, v2 = 0;
  logic [5:0] q[$];
  logic [5:0] e1 [64], e2 [64];
  bit k1 [64], k2 [64];
  typedef struct { int nsh; logic [3:0] a; bit simul; bit err1; } vec_t;
  vec_t tab [7];

  hub75_rx #(.NUM_PANELS(1)) u1 (.clk(clk), .rst_n(rst_n), .sclk(sclk), .lat(lat), .oe_n(oe_n),
    .addr(addr), .rgb1(rgb1), .rgb2(rgb2), .rd_col(rd_col), .rd_data(d1_rd), .line_vld(d1_vld),
    .line_row(d1_row), .line_err(d1_err), .shift_cnt(d1_cnt), .lit(d1_lit));
  hub75_rx #(.NUM_PANELS(2)) u2 (.clk(clk), .rst_n(rst_n), .sclk(sclk), .lat(lat), .oe_n(oe_n),
    .addr(addr), .rgb1(rgb1), .rgb2(rgb2), .rd_col(rd_col), .rd_data(d2_rd), .line_vld(d2_vld),
    .line_row(d2_row), .line_err(d2_err), .shift_cnt(d2_cnt), .lit(d2_lit));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (d1_vld) v1++;
    if (d2_vld) v2++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [5:0] p);
    {rgb1, rgb2} = p;
    sclk = 1;
    tick; tick;
    sclk = 0;
    tick; tick;
    q.push_back(p);
  endtask

  function automatic int sat(input int n, input int w);
    return n > w + 1 ? w + 1 : n;
  endfunction

  task automatic model_latch;
    int n;
    n = q.size();
    for (int k = 0; k < 64; k++) begin
      k1[k] = 0;
      k2[k] = 0;
      if (k < 32 && n >= 32) begin e1[k] = q[n-32+k]; k1[k] = 1; end
      else if (k < 32 && k < n) begin e1[k] = q[k]; k1[k] = 1; end
      if (n >= 64) begin e2[k] = q[n-64+k]; k2[k] = 1; end
      else if (k < n) begin e2[k] = q[k]; k2[k] = 1; end
    end
    q.delete();
  endtask

  task automatic latch(input logic [3:0] a, input bit simul, input logic [5:0] p);
    int b1, b2, n;
    b1 = v1;
    b2 = v2;
    chk("cnt1_pre", d1_cnt, sat(q.size(), 32));
    chk("cnt2_pre", d2_cnt, sat(q.size(), 64));
    if (simul) begin
      {rgb1, rgb2} = p;
      sclk = 1;
      q.push_back(p);
    end
    n = q.size();
    addr = a;
    lat = 1;
    tick; tick;
    lat = 0;
    sclk = 0;
    tick; tick;
    model_latch();
    chk("vld1_pulses", v1 - b1, 1);
    chk("vld2_pulses", v2 - b2, 1);
    chk("row1", d1_row, a);
    chk("row2", d2_row, a);
    chk("err1", d1_err, n != 32);
    chk("err2", d2_err, n != 64);
    chk("cnt1_post", d1_cnt, 0);
    chk("cnt2_post", d2_cnt, 0);
  endtask

  task automatic readback;
    for (int k = 0; k < 64; k++) begin
      rd_col = 8'(k);
      tick;
      if (k >= 32) chk("rd1_oob", d1_rd, 0);
      else if (k1[k]) chk("rd1", d1_rd, e1[k]);
      if (k2[k]) chk("rd2", d2_rd, e2[k]);
    end
    rd_col = 8'd255;
    tick;
    chk("rd1_255", d1_rd, 0);
    chk("rd2_255", d2_rd, 0);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_rd1"}, d1_rd, 0);   chk({tag, "_rd2"}, d2_rd, 0);
    chk({tag, "_vld1"}, d1_vld, 0); chk({tag, "_vld2"}, d2_vld, 0);
    chk({tag, "_row1"}, d1_row, 0); chk({tag, "_row2"}, d2_row, 0);
    chk({tag, "_err1"}, d1_err, 0); chk({tag, "_err2"}, d2_err, 0);
    chk({tag, "_cnt1"}, d1_cnt, 0); chk({tag, "_cnt2"}, d2_cnt, 0);
    chk({tag, "_lit1"}, d1_lit, 0); chk({tag, "_lit2"}, d2_lit, 0);
  endtask

  initial begin
    tab = '{'{32, 4'd5, 0, 0}, '{31, 4'd2, 0, 1}, '{33, 4'd9, 0, 1}, '{31, 4'd3, 1, 0},
            '{40, 4'd15, 0, 1}, '{63, 4'd1, 1, 1}, '{64, 4'd6, 0, 1}};
    #1;
    zero_outs("reset");
    tick; tick;
    rst_n = 1;
    tick;
    oe_n = 0;
    tick; tick; tick;
    chk("lit1_prelatch", d1_lit, 0);
    chk("lit2_prelatch", d2_lit, 0);
    oe_n = 1;
    tick; tick;
    for (int c = 0; c < 32; c++) shift({3'(c), ~3'(c)});
    latch(4'd5, 0, 6'd0);
    rd_col = 8'd7;
    tick;
    chk("rd1_col7", d1_rd, 6'b111000);
    chk("rd2_col7", d2_rd, 6'b111000);
    oe_n = 0;
    tick;
    chk("lit1_lat1", d1_lit, 0);
    tick;
    chk("lit1_lat2", d1_lit, 1);
    chk("lit2_lat2", d2_lit, 1);
    oe_n = 1;
    tick;
    chk("lit1_off1", d1_lit, 1);
    tick;
    chk("lit1_off2", d1_lit, 0);
    for (int i = 0; i < 7; i++) begin
      for (int s = 0; s < tab[i].nsh; s++) shift(6'($urandom));
      latch(tab[i].a, tab[i].simul, 6'($urandom));
      chk("err1_table", d1_err, tab[i].err1);
      readback();
    end
    for (int i = 0; i < 4; i++) begin
      int n;
      n = $urandom_range(20, 70);
      for (int s = 0; s < n; s++) shift(6'($urandom));
      latch(4'($urandom), bit'($urandom_range(0, 1)), 6'($urandom));
      readback();
    end
    oe_n = 0;
    tick; tick;
    for (int s = 0; s < 10; s++) shift(6'($urandom));
    sclk = 1;
    lat = 1;
    #2 rst_n = 0;
    #1;
    zero_outs("midreset");
    q.delete();
    tick; tick;
    rst_n = 1;
    begin
      int b1;
      b1 = v1;
      tick; tick; tick; tick;
      chk("held_cnt1", d1_cnt, 0);
      chk("held_cnt2", d2_cnt, 0);
      chk("held_vld1", v1 - b1, 0);
    end
    sclk = 0;
    lat = 0;
    oe_n = 1;
    tick; tick;
    for (int s = 0; s < 32; s++) shift(6'($urandom));
    latch(4'd12, 0, 6'd0);
    readback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 Parameter NUM_PANELS, default 1, number of chained 32-column panels; WIDTH = 32*NUM_PANELS.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 sclk  in  1  HUB75 shift clock; pixel data is accepted on its rising edge.
REQ-005 lat  in  1  HUB75 latch strobe; the shifted line is latched on its rising edge.
REQ-006 oe_n  in  1  HUB75 output enable, active-low (1 = blanked).
REQ-007 addr  in  4  HUB75 row address A-D.
REQ-008 rgb1  in  3  upper-half pixel {R1,G1,B1}.
REQ-009 rgb2  in  3  lower-half pixel {R2,G2,B2}.
REQ-010 rd_col  in  8  readback column index into the latched line.
REQ-011 rd_data  out  6  {rgb1,rgb2} of latched column rd_col.
REQ-012 line_vld  out  1  one-cycle pulse: new line latched.
REQ-013 line_row  out  4  row address captured at the last latch.
REQ-014 line_err  out  1  last latched line did not have exactly WIDTH shifts.
REQ-015 shift_cnt  out  8  sclk rising edges since the last latch, saturating.
REQ-016 lit  out  1  panel currently displaying (latched line valid and oe_n low).

Function
REQ-017 All HUB75 inputs (sclk, lat, oe_n, addr, rgb1, rgb2) SHALL be registered once into s_* stages; the edge detectors SHALL compare s_sclk/s_lat with a second registered copy p_sclk/p_lat.
REQ-018 Shift event: s_sclk=1 and p_sclk=0; the shift store SHALL take s_rgb1/s_rgb2 of that cycle on the following clk edge.
REQ-019 Column mapping: after a latch, column k (0..WIDTH-1) SHALL hold the k-th pixel shifted since the previous latch (k=0 first), matching the transmitter's col-0-first order.
REQ-020 Shift store is WIDTH entries deep; for more than WIDTH shifts the oldest pixel SHALL drop out, and column k SHALL hold the pixel shifted at position (n-WIDTH+k), where n is the total shift count.
REQ-021 shift_cnt SHALL increment per shift event, saturate at WIDTH+1, and clear to 0 on a latch event.
REQ-022 Latch event: s_lat=1 and p_lat=0; on the next clk edge the shift store SHALL be copied to the line buffer, line_row <= s_addr, line_err <= (shift_cnt != WIDTH), and line_vld SHALL pulse high for exactly that one cycle.
REQ-023 Simultaneous shift and latch event in one cycle: the shift SHALL be applied first, so the latched line and the count check include that pixel.
REQ-024 Held-high sclk or lat SHALL produce only one event per rising edge.
REQ-025 rd_data SHALL be registered: the value for rd_col presented at clk edge t appears after edge t+1; rd_col >= WIDTH SHALL return 6'b0.
REQ-026 lit SHALL equal (at least one latch since reset) AND NOT s_oe_n, registered.
REQ-027 The shift store SHALL continue to accept shifts while the line buffer is being displayed and read back, with no interaction between the two.

Reset
REQ-028 While rst_n=0, asynchronously: rd_data=0, line_vld=0, line_row=0, line_err=0, shift_cnt=0, lit=0; the shift store, line buffer, s_* and p_* stages SHALL clear to 0.
REQ-029 Deasserting reset mid-line SHALL discard all partial shifts; the first latch after reset with fewer than WIDTH shifts SHALL set line_err=1.
REQ-030 With sclk or lat high at reset release, no event SHALL fire until the signal goes low and then high again.

Verification
REQ-031 NUM_PANELS=1: 32 sclk pulses with rgb1=col[2:0], rgb2=~col[2:0], then lat pulse with addr=5 -> one line_vld pulse, line_row=5, line_err=0, rd_col=7 returns {3'b111,3'b000}.
REQ-032 31 shifts then lat -> line_err=1, shift_cnt=0 after the latch; 33 shifts then lat -> line_err=1, column 0 holds the 2nd pixel shifted.
REQ-033 Shift and lat rising edges in the same cycle as the 32nd shift -> line_err=0, column 31 holds that pixel.
REQ-034 oe_n toggling before and after the first latch -> lit=0 before the first latch; after it, lit follows ~oe_n with 2-cycle latency.
REQ-035 rst_n pulsed low after 10 shifts -> all outputs 0 immediately; 32 fresh shifts then lat -> line_err=0 with only the post-reset data.
REQ-036 rd_col=32 (NUM_PANELS=1) -> rd_data=0; NUM_PANELS=2 with 64 shifts -> line_err=0, rd_col=63 returns the last pixel shifted.
